// File: rtl/row_idwt97_pkg.sv
// Shared 9/7 lifting coefficients, FSM encoding and the multiply-round-saturate
// helpers used by the inverse row transform.
package row_idwt97_pkg;

    localparam int DATA_W   = 16;
    localparam int POINT    = 10;
    localparam int MAX_SIDE = 512;

    localparam real ALPHA = -1.586134342;
    localparam real BETA  = -0.052980118;
    localparam real GAMMA =  0.882911076;
    localparam real DELTA =  0.443506852;
    localparam real KAPPA =  1.230174105;

    localparam int ALPHA_Q = int'(ALPHA * (2.0 ** POINT));
    localparam int BETA_Q  = int'(BETA * (2.0 ** POINT));
    localparam int GAMMA_Q = int'(GAMMA * (2.0 ** POINT));
    localparam int DELTA_Q = int'(DELTA * (2.0 ** POINT));
    localparam int K_Q     = int'(KAPPA * (2.0 ** POINT));
    localparam int INV_K_Q = int'((1.0 / KAPPA) * (2.0 ** POINT));

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        RUN    = 2'd1,
        FLUSH1 = 2'd2,
        FLUSH2 = 2'd3
    } state_t;

    function automatic logic signed [DATA_W-1:0] sat_sample(input logic signed [47:0] v);
        logic signed [47:0] hi;
        logic signed [47:0] lo;
        hi = (48'sd1 <<< (DATA_W - 1)) - 48'sd1;
        lo = -(48'sd1 <<< (DATA_W - 1));
        if (v > hi) begin
            sat_sample = hi[DATA_W-1:0];
        end else if (v < lo) begin
            sat_sample = lo[DATA_W-1:0];
        end else begin
            sat_sample = v[DATA_W-1:0];
        end
    endfunction

    // x - c*(a+b): round half up before the arithmetic shift, then saturate
    function automatic logic signed [DATA_W-1:0] mul_sub(
        input logic signed [DATA_W-1:0] x,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b,
        input int                       c,
        input int                       pt
    );
        logic signed [DATA_W:0] sum;
        logic signed [47:0]     prod;
        sum  = (DATA_W + 1)'(a) + (DATA_W + 1)'(b);
        prod = 48'(sum) * 48'(c);
        prod = (prod + (48'sd1 <<< (pt - 1))) >>> pt;
        mul_sub = sat_sample(48'(x) - prod);
    endfunction

    function automatic logic signed [DATA_W-1:0] scale(
        input logic signed [DATA_W-1:0] x,
        input int                       c,
        input int                       pt
    );
        logic signed [47:0] prod;
        prod  = 48'(x) * 48'(c);
        scale = sat_sample((prod + (48'sd1 <<< (pt - 1))) >>> pt);
    endfunction

endpackage

// File: rtl/idwt97_lift_stage.sv
// One lifting step y = x - c*(a+b); a is the registered previous value of b,
// with optional left/right whole-sample mirroring.
module idwt97_lift_stage
    import row_idwt97_pkg::*;
#(
    parameter int Coef  = 0,
    parameter int Point = POINT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] b,
    input  logic                     mirror_left,
    input  logic                     mirror_right,
    output logic signed [DATA_W-1:0] y,
    output logic signed [DATA_W-1:0] prev
);

    logic signed [DATA_W-1:0] prev_r;
    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;

    // Neighbour register: keeps the b value of the previous pipeline step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r <= {DATA_W{1'b0}};
        end else if (en) begin
            prev_r <= b;
        end
    end

    // Mirror selection and the lifting arithmetic
    always_comb begin
        a_s = mirror_left  ? b      : prev_r;
        b_s = mirror_right ? prev_r : b;
        y   = mul_sub(x, a_s, b_s, Coef, Point);
    end

    assign prev = prev_r;

endmodule

// File: rtl/row_idwt97.sv
// Inverse 9/7 row transform: {high,low} subband pairs in, {odd,even} samples out,
// two pairs of latency plus one cycle, two flush steps per row.
module row_idwt97
    import row_idwt97_pkg::*;
#(
    parameter int DataWidth       = DATA_W,
    parameter int Point           = POINT,
    parameter int MaximumSideSize = MAX_SIDE
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic                   s_sof_i,
    input  logic                   s_eol_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o
);

    localparam int CNT_W = $clog2(MaximumSideSize);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s, cnt_inc_s;
    logic               ready_en_r;
    logic               out_free_s, accept_s, flushing_s, advance_s;
    logic               beat0_s, beat1_s, emit_s;

    logic signed [DATA_W-1:0] sc_s_s, sc_d_s;
    logic signed [DATA_W-1:0] sp_s, d_prev_s, dp_s, sp_prev_s, xe_s, dp_prev_s, xo_s, xe_prev_s;

    // Handshake, advance and boundary-beat decode
    always_comb begin
        out_free_s = !m_valid_o || m_ready_i;
        flushing_s = (state_r == FLUSH1) || (state_r == FLUSH2);
        s_ready_o  = ready_en_r && !flushing_s && out_free_s;
        accept_s   = s_valid_i && s_ready_o;
        advance_s  = accept_s || (flushing_s && out_free_s);
        beat0_s    = accept_s && (s_sof_i || ((state_r == FILL) && (cnt_r == CNT_W'(0))));
        beat1_s    = accept_s && !beat0_s && (state_r == FILL) && (cnt_r == CNT_W'(1));
        emit_s     = advance_s && (((state_r == RUN) && !beat0_s) || flushing_s);
        cnt_inc_s  = (cnt_r == {CNT_W{1'b1}}) ? cnt_r : cnt_r + CNT_W'(1);
        sc_s_s     = scale(s_data_i[DataWidth-1:0], K_Q, Point);
        sc_d_s     = scale(s_data_i[2*DataWidth-1:DataWidth], INV_K_Q, Point);
    end

    // Next-state and pair counter
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            FILL, RUN: begin
                if (accept_s) begin
                    cnt_s = beat0_s ? CNT_W'(1) : cnt_inc_s;
                    if (s_eol_i) begin
                        state_s = FLUSH1;
                    end else if (beat0_s) begin
                        state_s = FILL;
                    end else if (beat1_s) begin
                        state_s = RUN;
                    end else begin
                        state_s = state_r;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            FLUSH1: begin
                if (out_free_s) begin
                    state_s = FLUSH2;
                    cnt_s   = cnt_inc_s;
                end else begin
                    state_s = state_r;
                end
            end
            FLUSH2: begin
                if (out_free_s) begin
                    state_s = FILL;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = FILL;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, counter and the post-reset ready enable
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= FILL;
            cnt_r      <= {CNT_W{1'b0}};
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            ready_en_r <= 1'b1;
        end
    end

    idwt97_lift_stage #(.Coef(DELTA_Q), .Point(Point)) u_delta (
        .clk(clk_i), .rst_n(rst_ni), .en(advance_s), .x(sc_s_s), .b(sc_d_s),
        .mirror_left(beat0_s), .mirror_right(1'b0), .y(sp_s), .prev(d_prev_s));

    idwt97_lift_stage #(.Coef(GAMMA_Q), .Point(Point)) u_gamma (
        .clk(clk_i), .rst_n(rst_ni), .en(advance_s), .x(d_prev_s), .b(sp_s),
        .mirror_left(1'b0), .mirror_right(state_r == FLUSH1), .y(dp_s), .prev(sp_prev_s));

    idwt97_lift_stage #(.Coef(BETA_Q), .Point(Point)) u_beta (
        .clk(clk_i), .rst_n(rst_ni), .en(advance_s), .x(sp_prev_s), .b(dp_s),
        .mirror_left(beat1_s), .mirror_right(1'b0), .y(xe_s), .prev(dp_prev_s));

    idwt97_lift_stage #(.Coef(ALPHA_Q), .Point(Point)) u_alpha (
        .clk(clk_i), .rst_n(rst_ni), .en(advance_s), .x(dp_prev_s), .b(xe_s),
        .mirror_left(1'b0), .mirror_right(state_r == FLUSH2), .y(xo_s), .prev(xe_prev_s));

    // Output register: loads on emit, holds while the sink stalls
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_valid_o <= 1'b0;
            m_sof_o   <= 1'b0;
            m_eol_o   <= 1'b0;
            m_data_o  <= {(2 * DataWidth){1'b0}};
        end else if (out_free_s) begin
            m_valid_o <= emit_s;
            if (emit_s) begin
                m_data_o <= {xo_s, xe_prev_s};
                m_sof_o  <= (cnt_r == CNT_W'(2));
                m_eol_o  <= (state_r == FLUSH2);
            end
        end
    end

endmodule

// File: tb/tb_row_idwt97.sv
// Directed/randomized bench for row_idwt97 against an array-level model of the
// inverse 9/7 lifting equations (plus a real-valued forward model for round trip).
module tb_row_idwt97;
    import row_idwt97_pkg::*;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        s_ready_o, s_valid_i, s_sof_i, s_eol_i;
    logic [31:0] s_data_i;
    logic        m_ready_i, m_valid_o, m_sof_o, m_eol_o;
    logic [31:0] m_data_o;

    int vectors = 0;
    int miscompares = 0;

    int bq_hi[$], bq_lo[$];
    bit bq_sof[$], bq_eol[$];
    int r_hi[$], r_lo[$], src[$];
    int ex_e[$], ex_o[$], got_e[$], got_o[$];
    bit ex_sof[$], ex_eol[$], got_sof[$], got_eol[$];

    bit          hold_v = 1'b0;
    logic [31:0] hold_d;
    logic [1:0]  hold_f;

    row_idwt97 dut (
        .clk_i(clk), .rst_ni(rst_ni), .s_ready_o(s_ready_o), .s_valid_i(s_valid_i),
        .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_data_i(s_data_i), .m_ready_i(m_ready_i),
        .m_valid_o(m_valid_o), .m_sof_o(m_sof_o), .m_eol_o(m_eol_o), .m_data_o(m_data_o));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat16(input longint v);
        return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
    endfunction

    function automatic longint lift(input longint x, input longint a, input longint b, input longint c);
        return sat16(x - (((a + b) * c + 512) >>> 10));
    endfunction

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Sink monitor: records transfers and checks the held beat while stalled
    always @(negedge clk) begin
        if (!rst_ni) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("stall_valid", m_valid_o, 1);
                chk("stall_data", m_data_o, hold_d);
                chk("stall_flags", {m_sof_o, m_eol_o}, hold_f);
            end
            if (m_valid_o && m_ready_i) begin
                got_e.push_back(int'($signed(m_data_o[15:0])));
                got_o.push_back(int'($signed(m_data_o[31:16])));
                got_sof.push_back(m_sof_o);
                got_eol.push_back(m_eol_o);
            end
            hold_v = m_valid_o && !m_ready_i;
            hold_d = m_data_o;
            hold_f = {m_sof_o, m_eol_o};
        end
    end

    // Reference: whole-row arrays straight from the inverse lifting equations
    task automatic ref_row(input int n_emit, input bit full_row);
        int  n = r_lo.size();
        longint s[], d[], sp[], dp[], x[];
        s = new[n]; d = new[n]; sp = new[n]; dp = new[n]; x = new[2 * n];
        for (int i = 0; i < n; i++) begin
            s[i] = sat16((longint'(r_lo[i]) * K_Q + 512) >>> 10);
            d[i] = sat16((longint'(r_hi[i]) * INV_K_Q + 512) >>> 10);
        end
        for (int i = 0; i < n; i++) sp[i] = lift(s[i], d[(i == 0) ? 0 : i - 1], d[i], DELTA_Q);
        for (int i = 0; i < n; i++) dp[i] = lift(d[i], sp[i], sp[(i == n - 1) ? n - 1 : i + 1], GAMMA_Q);
        for (int i = 0; i < n; i++) x[2 * i] = lift(sp[i], dp[(i == 0) ? 0 : i - 1], dp[i], BETA_Q);
        for (int i = 0; i < n; i++)
            x[2 * i + 1] = lift(dp[i], x[2 * i], x[(i == n - 1) ? 2 * n - 2 : 2 * i + 2], ALPHA_Q);
        for (int i = 0; i < n_emit; i++) begin
            ex_e.push_back(int'(x[2 * i]));
            ex_o.push_back(int'(x[2 * i + 1]));
            ex_sof.push_back(i == 0);
            ex_eol.push_back(full_row && (i == n - 1));
        end
    endtask

    // Forward 9/7 in real arithmetic: random source row -> quantized subbands
    task automatic fwd_row(input int n);
        real d[], s[];
        d = new[n]; s = new[n];
        src.delete(); r_hi.delete(); r_lo.delete();
        for (int i = 0; i < 2 * n; i++) src.push_back(int'($urandom_range(1024)) - 512);
        for (int i = 0; i < n; i++) d[i] = src[2*i+1] + ALPHA * (src[2*i] + src[(i == n-1) ? 2*n-2 : 2*i+2]);
        for (int i = 0; i < n; i++) s[i] = src[2*i] + BETA * (d[(i == 0) ? 0 : i-1] + d[i]);
        for (int i = 0; i < n; i++) d[i] = d[i] + GAMMA * (s[i] + s[(i == n-1) ? n-1 : i+1]);
        for (int i = 0; i < n; i++) s[i] = s[i] + DELTA * (d[(i == 0) ? 0 : i-1] + d[i]);
        for (int i = 0; i < n; i++) begin
            r_lo.push_back(rnd(s[i] / KAPPA));
            r_hi.push_back(rnd(d[i] * KAPPA));
        end
    endtask

    task automatic rand_row(input int n, input int range);
        r_hi.delete(); r_lo.delete();
        for (int i = 0; i < n; i++) begin
            r_hi.push_back(int'($urandom_range(2 * range)) - range);
            r_lo.push_back(int'($urandom_range(2 * range)) - range);
        end
    endtask

    task automatic push_row(input int n_beats, input bit with_eol);
        for (int i = 0; i < n_beats; i++) begin
            bq_hi.push_back(r_hi[i]);
            bq_lo.push_back(r_lo[i]);
            bq_sof.push_back(i == 0);
            bq_eol.push_back(with_eol && (i == n_beats - 1));
        end
    endtask

    task automatic drive_beats(input int stall_pct);
        bit took;
        int budget;
        for (int k = 0; k < bq_lo.size(); k++) begin
            s_valid_i = 1'b1;
            s_data_i  = {16'(bq_hi[k]), 16'(bq_lo[k])};
            s_sof_i   = bq_sof[k];
            s_eol_i   = bq_eol[k];
            took = 1'b0;
            budget = 0;
            while (!took && budget < 200) begin
                @(negedge clk);
                took = s_ready_o;
                @(posedge clk);
                #1;
                m_ready_i = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= stall_pct);
                budget++;
            end
            chk("accept_timeout", took, 1);
        end
        s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0; m_ready_i = 1'b1;
        bq_hi.delete(); bq_lo.delete(); bq_sof.delete(); bq_eol.delete();
    endtask

    task automatic wait_outputs();
        int budget = 0;
        while (got_e.size() < ex_e.size() && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        repeat (4) @(negedge clk);
        chk("out_count", got_e.size(), ex_e.size());
    endtask

    task automatic compare_outputs();
        for (int i = 0; i < ex_e.size() && i < got_e.size(); i++) begin
            chk("even", got_e[i], ex_e[i]);
            chk("odd", got_o[i], ex_o[i]);
            chk("sof", got_sof[i], ex_sof[i]);
            chk("eol", got_eol[i], ex_eol[i]);
        end
        ex_e.delete(); ex_o.delete(); ex_sof.delete(); ex_eol.delete();
        got_e.delete(); got_o.delete(); got_sof.delete(); got_eol.delete();
    endtask

    initial begin
        int low_cycles;
        rst_ni = 1'b0; s_valid_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0;
        s_data_i = 32'd0; m_ready_i = 1'b1;

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", m_valid_o, 0);
        chk("rst_sof", m_sof_o, 0);
        chk("rst_eol", m_eol_o, 0);
        chk("rst_data", m_data_o, 0);
        chk("rst_ready", s_ready_o, 0);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", s_ready_o, 1);

        // DC row: unit low band, zero high band
        r_hi = '{0, 0, 0, 0};
        r_lo = '{1024, 1024, 1024, 1024};
        ref_row(4, 1'b1);
        push_row(4, 1'b1);
        drive_beats(0);
        wait_outputs();
        for (int i = 0; i < got_e.size(); i++) begin
            chk("dc_even_tol", iabs(got_e[i] - 1024) <= 2, 1);
            chk("dc_odd_tol", iabs(got_o[i] - 1024) <= 2, 1);
        end
        compare_outputs();

        // Zero row N=2: both outputs come from the flush steps
        r_hi = '{0, 0};
        r_lo = '{0, 0};
        ref_row(2, 1'b1);
        push_row(2, 1'b1);
        drive_beats(0);
        low_cycles = 0;
        while (low_cycles < 20) begin
            @(negedge clk);
            if (s_ready_o) break;
            low_cycles++;
        end
        chk("flush_ready_low", low_cycles, 2);
        wait_outputs();
        compare_outputs();

        // Round trip through the real-valued forward transform
        fwd_row(16);
        ref_row(16, 1'b1);
        push_row(16, 1'b1);
        drive_beats(0);
        wait_outputs();
        for (int i = 0; i < got_e.size() && i < 16; i++) begin
            chk("rt_even_tol", iabs(got_e[i] - src[2 * i]) <= 4, 1);
            chk("rt_odd_tol", iabs(got_o[i] - src[2 * i + 1]) <= 4, 1);
        end
        compare_outputs();

        // Backpressure on an 8-pair row, then full-range data hitting saturation
        rand_row(8, 3000);
        ref_row(8, 1'b1);
        push_row(8, 1'b1);
        drive_beats(50);
        wait_outputs();
        compare_outputs();
        rand_row(6, 32767);
        ref_row(6, 1'b1);
        push_row(6, 1'b1);
        drive_beats(30);
        wait_outputs();
        compare_outputs();

        // Abort: new sof on beat 3 of a row
        rand_row(3, 2000);
        ref_row(1, 1'b0);
        push_row(3, 1'b0);
        rand_row(5, 2000);
        ref_row(5, 1'b1);
        push_row(5, 1'b1);
        drive_beats(0);
        wait_outputs();
        compare_outputs();

        // Reset during RUN, then a clean row
        rand_row(8, 2000);
        push_row(5, 1'b0);
        drive_beats(0);
        chk("pre_rst_valid", m_valid_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", m_valid_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        got_e.delete(); got_o.delete(); got_sof.delete(); got_eol.delete();
        rand_row(6, 2000);
        ref_row(6, 1'b1);
        push_row(6, 1'b1);
        drive_beats(0);
        wait_outputs();
        compare_outputs();

        // Row longer than the nominal maximum
        rand_row(300, 3000);
        ref_row(300, 1'b1);
        push_row(300, 1'b1);
        drive_beats(10);
        wait_outputs();
        compare_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
